// File: rtl/data_bus_responder.sv
// Data-bus responder for the single-cycle core: word RAM plus an MMIO page holding
// a free-running cycle counter with compare flag and a byte-wide console TX FIFO.
module data_bus_responder #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_write,
  output logic [31:0] bus_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = FIFO_AW + 1;

  localparam logic [27:0] IO_PAGE    = 28'h800_0000;
  localparam logic [1:0]  REG_CYCLE  = 2'd0;
  localparam logic [1:0]  REG_CMP    = 2'd1;
  localparam logic [1:0]  REG_STATUS = 2'd2;

  logic [31:0]        ram_mem  [RAM_WORDS];
  logic [7:0]         fifo_mem [FIFO_DEPTH];

  logic [31:0]        cycle_q, cycle_d;
  logic [31:0]        cmp_q, cmp_d;
  logic               hit_q, hit_d;
  logic               ovf_q, ovf_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               ram_sel, io_sel;
  logic [1:0]         reg_idx;
  logic [RAM_AW-1:0]  ram_idx;
  logic               ram_we, cmp_we, stat_we, tx_we;
  logic               fifo_full, fifo_empty, push, pop, ovf_set;
  logic [31:0]        status;
  logic               unused_addr;

  // Address decode; the two low address bits never participate.
  assign ram_sel     = (bus_addr[31:RAM_AW+2] == '0);
  assign io_sel      = (bus_addr[31:4] == IO_PAGE);
  assign reg_idx     = bus_addr[3:2];
  assign ram_idx     = bus_addr[RAM_AW+1:2];
  assign unused_addr = ^bus_addr[1:0];

  // A store seen while reset is held must not land in the (unreset) RAM.
  assign ram_we  = bus_write & ram_sel & rst_n;
  assign cmp_we  = bus_write & io_sel & (reg_idx == REG_CMP);
  assign stat_we = bus_write & io_sel & (reg_idx == REG_STATUS);
  assign tx_we   = bus_write & io_sel & (reg_idx == 2'd3);

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = ~fifo_empty & tx_ready;
  assign push       = tx_we & (~fifo_full | pop);
  assign ovf_set    = tx_we & fifo_full & ~pop;

  assign tx_valid = ~fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

  assign status = {16'h0000, 8'(count_q), 4'h0, ovf_q, fifo_empty, fifo_full, hit_q};

  // Next-state: sticky flags let a same-edge set override a W1C clear.
  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    cmp_d    = cmp_q;
    hit_d    = hit_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (cmp_we) cmp_d = bus_wdata;
    if (stat_we && bus_wdata[0]) hit_d = 1'b0;
    if (stat_we && bus_wdata[3]) ovf_d = 1'b0;
    if (cycle_q == cmp_q) hit_d = 1'b1;
    if (ovf_set) ovf_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q  <= '0;
      cmp_q    <= '1;
      hit_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      cycle_q  <= cycle_d;
      cmp_q    <= cmp_d;
      hit_q    <= hit_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage arrays carry no reset; FIFO slots are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[ram_idx] <= bus_wdata;
    if (push)   fifo_mem[wr_ptr_q] <= bus_wdata[7:0];
  end

  // Load path is purely combinational and side-effect free.
  always_comb begin
    bus_rdata = '0;
    if (ram_sel) begin
      bus_rdata = ram_mem[ram_idx];
    end else if (io_sel) begin
      case (reg_idx)
        REG_CYCLE:  bus_rdata = cycle_q;
        REG_CMP:    bus_rdata = cmp_q;
        REG_STATUS: bus_rdata = status;
        default:    bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: register/RAM reads checked directly,
// console bytes checked through a scoreboard queue as the sink accepts them.
module tb_data_bus_responder;

  localparam int unsigned DEPTH    = 8;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
  localparam logic [31:0] A_CMP    = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;
  localparam logic [31:0] A_TX     = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  exp_q[$];
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  data_bus_responder #(.RAM_WORDS(1024), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_write (bus_write),
    .bus_rdata (bus_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] status_exp(input logic hit, input logic ovf, input int cnt);
    return {16'h0000, 8'(cnt), 4'h0, ovf, (cnt == 0), (cnt == int'(DEPTH)), hit};
  endfunction

  // Drive a store right after a negedge; it commits on the next posedge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_write = 1'b1;
    @(negedge clk);
    bus_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_write = 1'b0;
    bus_addr  = a;
    #1;
    d = bus_rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] v;
    rd(a, v);
    check_eq(tag, v, e);
  endtask

  // Model decides acceptance at drive time; the byte enters the scoreboard once committed.
  task automatic push_byte(input logic [7:0] b);
    logic ok;
    ok = (exp_q.size() < int'(DEPTH)) || (tx_ready && exp_q.size() > 0);
    if (!ok) m_ovf = 1'b1;
    bus_wr(A_TX, {24'h0, b});
    if (ok) exp_q.push_back(b);
  endtask

  // Sink-side monitor, sampling just before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      check_eq("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
      if (tx_valid && exp_q.size() != 0) begin
        check_eq("tx_data", 32'(tx_data), 32'(exp_q[0]));
        if (tx_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] prev, cur;

    repeat (2) @(negedge clk);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_tx_data", 32'(tx_data), 32'h0);
    rd_chk("rst_status", A_STATUS, 32'h0000_0004);
    rd_chk("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    rd_chk("rst_cycle", A_CYCLE, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("cycle_0", A_CYCLE, 32'd0);
    @(negedge clk);
    rd_chk("cycle_1", A_CYCLE, 32'd1);
    @(negedge clk);
    rd_chk("cycle_2", A_CYCLE, 32'd2);

    // RAM store/load ordering and decode holes
    @(negedge clk);
    bus_wr(32'h0000_0010, 32'h1111_1111);
    bus_addr  = 32'h0000_0010;
    bus_wdata = 32'hDEAD_BEEF;
    bus_write = 1'b1;
    #1;
    check_eq("ram_same_cycle", bus_rdata, 32'h1111_1111);
    @(negedge clk);
    bus_write = 1'b0;
    rd_chk("ram_next_cycle", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_byte_offset", 32'h0000_0013, 32'hDEAD_BEEF);
    rd_chk("unmapped_rd", 32'h4000_0000, 32'h0);
    @(negedge clk);
    rd_chk("io_hole_rd", 32'h8000_0010, 32'h0);
    rd_chk("txdata_rd", A_TX, 32'h0);
    bus_wr(32'h0000_1010, 32'hCAFE_F00D);
    rd_chk("ram_no_alias", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("above_ram_rd", 32'h0000_1010, 32'h0);

    // Counter increments and compare hit at 20
    @(negedge clk);
    bus_wr(A_CMP, 32'd20);
    rd_chk("cmp_rd", A_CMP, 32'd20);
    rd(A_CYCLE, prev);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rd(A_CYCLE, cur);
      check_eq("cycle_inc", cur, prev + 32'd1);
      prev = cur;
      if (cur == 32'd20) begin
        rd_chk("hit_before_match", A_STATUS, status_exp(1'b0, 1'b0, 0));
        break;
      end
    end
    @(negedge clk);
    rd_chk("cycle_21", A_CYCLE, 32'd21);
    rd_chk("hit_set", A_STATUS, status_exp(1'b1, 1'b0, 0));
    bus_wr(A_STATUS, 32'h1);
    rd_chk("hit_clr", A_STATUS, status_exp(1'b0, 1'b0, 0));

    // Clear landing on the matching edge: the set wins
    @(negedge clk);
    rd(A_CYCLE, cur);
    bus_wr(A_CMP, cur + 32'd5);
    repeat (3) @(negedge clk);
    rd_chk("cycle_pre_match", A_CYCLE, cur + 32'd4);
    @(negedge clk);
    rd_chk("hit_pre_match", A_STATUS, status_exp(1'b0, 1'b0, 0));
    bus_wr(A_STATUS, 32'h1);
    rd_chk("hit_set_wins", A_STATUS, status_exp(1'b1, 1'b0, 0));
    bus_wr(A_STATUS, 32'h1);
    rd_chk("hit_clr2", A_STATUS, status_exp(1'b0, 1'b0, 0));

    // Fill past full, clear OVF, drain; three rounds wrap the pointers
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      tx_ready = 1'b0;
      for (int b = 0; b < 9; b++) push_byte(8'h41 + 8'(b));
      check_eq("fill_head", 32'(tx_data), 32'h41);
      rd_chk("fill_status", A_STATUS, status_exp(1'b0, m_ovf, exp_q.size()));
      check_eq("fill_status_abs", status_exp(1'b0, m_ovf, exp_q.size()), 32'h0000_080A);
      bus_wr(A_STATUS, 32'h8);
      m_ovf = 1'b0;
      rd_chk("ovf_clr", A_STATUS, status_exp(1'b0, m_ovf, exp_q.size()));
      tx_ready = 1'b1;
      repeat (8) @(negedge clk);
      check_eq("drain_left", 32'(exp_q.size()), 32'd0);
      rd_chk("drain_status", A_STATUS, 32'h0000_0004);
      tx_ready = 1'b0;
    end

    // Push while full with a simultaneous pop
    @(negedge clk);
    for (int b = 0; b < 8; b++) push_byte(8'h61 + 8'(b));
    rd_chk("pp_full", A_STATUS, status_exp(1'b0, 1'b0, 8));
    tx_ready = 1'b1;
    push_byte(8'h5A);
    rd_chk("pp_status", A_STATUS, status_exp(1'b0, m_ovf, exp_q.size()));
    check_eq("pp_count", 32'(exp_q.size()), 32'd8);
    repeat (8) @(negedge clk);
    check_eq("pp_drain_left", 32'(exp_q.size()), 32'd0);
    rd_chk("pp_empty", A_STATUS, 32'h0000_0004);
    tx_ready = 1'b0;

    // Reset asserted mid-run during a push and an active handshake
    @(negedge clk);
    push_byte(8'h31);
    push_byte(8'h32);
    bus_addr  = A_TX;
    bus_wdata = 32'h0000_0077;
    bus_write = 1'b1;
    tx_ready  = 1'b1;
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    #1;
    check_eq("rstmid_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("rstmid_tx_data", 32'(tx_data), 32'h0);
    @(posedge clk);
    #1;
    check_eq("rstmid_drop_push", 32'(tx_valid), 32'h0);
    rd_chk("rstmid_status", A_STATUS, 32'h0000_0004);
    rd_chk("rstmid_cmp", A_CMP, 32'hFFFF_FFFF);
    @(negedge clk);
    tx_ready = 1'b0;
    rst_n = 1'b1;
    rd_chk("rel_cycle", A_CYCLE, 32'd0);
    rd_chk("rel_status", A_STATUS, 32'h0000_0004);
    rd_chk("ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);

    // Counter wrap; CMP is back at all-ones so the wrap also raises HIT
    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFE;
    rd_chk("wrap_fe", A_CYCLE, 32'hFFFF_FFFE);
    release dut.cycle_q;
    @(negedge clk);
    rd_chk("wrap_ff", A_CYCLE, 32'hFFFF_FFFF);
    rd_chk("wrap_nohit", A_STATUS, 32'h0000_0004);
    @(negedge clk);
    rd_chk("wrap_00", A_CYCLE, 32'h0000_0000);
    rd_chk("wrap_hit", A_STATUS, 32'h0000_0005);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Responder for the single-cycle core's data bus. Decodes every data access into word RAM or a small memory-mapped I/O page: a free-running cycle counter with compare flag, and a byte-wide console transmit FIFO drained over a valid/ready port. Reads are combinational to meet the core's same-cycle load. Writes commit on the rising clock edge.

## Interface
- RAM_WORDS, 1024: RAM depth in 32-bit words; power of 2.
- FIFO_DEPTH, 8: console FIFO depth in bytes; power of 2, at least 2.

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- bus_addr  input  32  byte address from core (core's data_addr)
- bus_wdata  input  32  store data from core (core's data_out)
- bus_write  input  1  store strobe from core (core's data_write)
- bus_rdata  output  32  load data to core (core's data_in), combinational
- tx_data  output  8  FIFO head byte
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  sink accepts tx_data this cycle

## Operation
- bus_addr[1:0] ignored; all accesses are full-word.
- Address map:
  - 0x0000_0000 to RAM_WORDS*4-1 is RAM, indexed by bus_addr[log2(RAM_WORDS)+1:2]. Contents are not reset.
  - 0x8000_0000 is CYCLE, read-only. 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF to 0.
  - 0x8000_0004 is CMP, read/write. Reset value 0xFFFF_FFFF.
  - 0x8000_0008 is STATUS. Fields:
    - bit0 HIT: sticky, write-1-to-clear.
    - bit1 FULL: read-only.
    - bit2 EMPTY: read-only.
    - bit3 OVF: sticky, write-1-to-clear.
    - bits[15:8] COUNT: FIFO occupancy.
    - All other bits read 0.
  - 0x8000_000C is TXDATA, write-only. A write pushes bus_wdata[7:0]. Reads return 0.
  - Any other address reads 0; writes to it are ignored.
- bus_rdata is a pure function of bus_addr and current register and RAM state. Loads never have side effects.
- HIT is set on the edge where the registered CYCLE value equals CMP.
- HIT/OVF W1C: if a clear and a set happen in the same cycle, the set wins.
- Push rules:
  - A push while full with no pop is dropped and sets OVF.
  - A push while full with a simultaneous pop is accepted; COUNT is unchanged.
- Pop: occurs on an edge with tx_valid && tx_ready.
- tx_data shows the FIFO head. It stays stable while tx_valid is high and tx_ready is low.
- Pointers are log2(FIFO_DEPTH) bits with a separate count register. Wrap-around is transparent.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately):
  - CYCLE=0, CMP=0xFFFF_FFFF, HIT=0, OVF=0.
  - FIFO empty; tx_valid=0; tx_data=0.
  - bus_rdata follows decode, e.g. STATUS reads 0x0000_0004.
- Reset during a store or a handshake drops both; no partial state is left.
- Deassertion: CYCLE reads 0 in the first cycle after rst_n rises, then 1, 2, and so on.
- Store latency: 1 edge. A load from the same address in the next cycle returns the new value.
- A load in the same cycle as a store returns the old value.
- CMP written to value V at edge t: the compare uses V from edge t+1 onward.
- TXDATA write at edge t: tx_valid=1 and COUNT updated right after edge t. The earliest pop is at edge t+1.
- FIFO throughput: 1 push and 1 pop per cycle, sustained.

## Test plan
- Reset and RAM:
  - Assert rst_n low mid-run. Required: tx_valid=0 immediately, STATUS=0x0000_0004, CMP=0xFFFF_FFFF.
  - Store 0xDEADBEEF to 0x0000_0010, then load it. Required: next-cycle load returns 0xDEADBEEF; same-cycle load returns the old value.
  - Unmapped 0x4000_0000 reads 0.
- Counter/compare:
  - Release reset; write CMP=20. Required: CYCLE readback increments by 1 per cycle; HIT reads 1 after CYCLE passes 20.
  - Write STATUS=0x1 clears HIT. A clear on the same edge as a match leaves HIT=1.
- FIFO fill/overflow:
  - With tx_ready=0, push 0x41 through 0x49 (9 bytes, depth 8). Required: FULL=1, COUNT=8, OVF=1, tx_data=0x41 held stable.
  - W1C OVF; required: OVF reads 0.
- Drain/wrap:
  - Raise tx_ready. Required: bytes 0x41 through 0x48 emerge in order, one per cycle, then EMPTY=1.
  - Repeat 3 times to exercise pointer wrap.
- Simultaneous push/pop at full:
  - FIFO full, tx_ready=1, push 0x5A in the same cycle. Required: COUNT stays 8, OVF stays 0, 0x5A is delivered last.
- CYCLE wrap: force CYCLE near 0xFFFF_FFFE. Required: readback sequence 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
